// File: rtl/simd_pkg.sv
// Shared defaults for the SIMD matrix datapath (mat_mul and its result serializer).
package simd_pkg;

  localparam int unsigned W_IN_DEF  = 8;
  localparam int unsigned W_OUT_DEF = 32;
  localparam int unsigned N_DEF     = 8;

endpackage

// File: rtl/mat_pingpong_buf.sv
// Two-slot ping-pong matrix store with write/read pointers and an occupancy count.
module mat_pingpong_buf
  import simd_pkg::*;
#(
  parameter int unsigned W_OUT = W_OUT_DEF,
  parameter int unsigned N     = N_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic                             rd_done,
  input  logic [N-1:0][N-1:0][W_OUT-1:0]   wr_data,
  output logic [N-1:0][N-1:0][W_OUT-1:0]   rd_data,
  output logic                             in_ready,
  output logic                             empty
);

  logic [N-1:0][N-1:0][W_OUT-1:0] slot [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  // Slot storage carries no reset; only valid entries are ever read out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        wr_ptr <= ~wr_ptr;
      end
      if (rd_done) begin
        rd_ptr <= ~rd_ptr;
      end
      // A fill and a drain in the same cycle leave occupancy unchanged.
      unique case ({wr_en, rd_done})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data  = slot[rd_ptr];
  assign in_ready = (count < 2'd2);
  assign empty    = (count == 2'd0);

endmodule

// File: rtl/mat_result_serializer.sv
// Captures N x N result matrices into a ping-pong buffer and streams them
// out row-major, one element per beat, with a last-beat marker and overrun flag.
module mat_result_serializer
  import simd_pkg::*;
#(
  parameter int unsigned W_OUT = W_OUT_DEF,
  parameter int unsigned N     = N_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cen,
  input  logic                             valid_in,
  input  logic [N-1:0][N-1:0][W_OUT-1:0]   result,
  output logic                             in_ready,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [W_OUT-1:0]                 m_data,
  output logic                             m_last,
  output logic                             overrun
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);

  logic [N-1:0][N-1:0][W_OUT-1:0] rd_mat;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic          empty;
  logic          capture;
  logic          drop;
  logic          transfer;
  logic          last_done;

  // Capture/drop decisions use occupancy at the start of the cycle.
  assign capture   = cen && valid_in && in_ready;
  assign drop      = cen && valid_in && !in_ready;
  assign transfer  = cen && m_valid && m_ready;
  assign last_done = transfer && m_last;

  mat_pingpong_buf #(
    .W_OUT (W_OUT),
    .N     (N)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (capture),
    .rd_done  (last_done),
    .wr_data  (result),
    .rd_data  (rd_mat),
    .in_ready (in_ready),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      overrun <= 1'b0;
    end else if (cen) begin
      if (transfer) begin
        if (m_last) begin
          row <= '0;
          col <= '0;
        end else if (col == IDX_LAST) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  // Output mux reads registers only; no path from any input.
  assign m_valid = !empty;
  assign m_data  = m_valid ? rd_mat[row][col] : '0;
  assign m_last  = m_valid && (row == IDX_LAST) && (col == IDX_LAST);

endmodule

// File: tb/tb_mat_result_serializer.sv
// Directed, self-checking bench for mat_result_serializer (N=8, W_OUT=32).
module tb_mat_result_serializer;

  localparam int N = 8;
  localparam int W = 32;
  localparam int E = N * N;

  logic clk = 1'b0;
  logic rst, cen, valid_in, m_ready;
  logic [N-1:0][N-1:0][W-1:0] result;
  logic in_ready, m_valid, m_last, overrun;
  logic [W-1:0] m_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    int base;
    bit neg00;
    bit alt;
    int exp_cycles;
  } vec_t;

  always #5 clk = ~clk;

  mat_result_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .valid_in (valid_in),
    .result   (result),
    .in_ready (in_ready),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .overrun  (overrun)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0][N-1:0][W-1:0] mk_mat(input int base, input bit neg00);
    logic [N-1:0][N-1:0][W-1:0] m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = W'(base + i * N + j);
    if (neg00) m[0][0] = '1;
    return m;
  endfunction

  task automatic push_exp(input int base, input bit neg00);
    beat_t b;
    for (int k = 0; k < E; k++) begin
      b.d = (neg00 && k == 0) ? '1 : W'(base + k);
      b.l = (k == E - 1);
      exp_q.push_back(b);
    end
  endtask

  // One capture pulse; returns positioned at the negedge after the capturing edge.
  task automatic capture(input int base, input bit neg00);
    valid_in = 1'b1;
    result   = mk_mat(base, neg00);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Drives m_ready/cen each cycle, checks every accepted beat and stall stability.
  task automatic drain(input bit alt, input int cen_at, input int max_beats,
                       input int budget, output int cycles);
    int popped = 0;
    int cen_left = 5;
    bit r = 1'b1;
    bit hold_pend = 1'b0;
    logic [W-1:0] held_d = '0;
    logic held_l = 1'b0;
    beat_t b;
    cycles = 0;
    while (exp_q.size() > 0 && popped < max_beats && cycles < budget) begin
      if (hold_pend) begin
        check("stall_data", m_data, held_d);
        check("stall_last", W'(m_last), W'(held_l));
      end
      m_ready = alt ? r : 1'b1;
      r = ~r;
      if (popped == cen_at && cen_left > 0) begin
        cen = 1'b0;
        cen_left--;
      end else begin
        cen = 1'b1;
      end
      if (cen && m_valid && m_ready) begin
        b = exp_q.pop_front();
        check("beat_data", m_data, b.d);
        check("beat_last", W'(m_last), W'(b.l));
        popped++;
        hold_pend = 1'b0;
      end else if (m_valid) begin
        hold_pend = 1'b1;
        held_d = m_data;
        held_l = m_last;
      end else begin
        hold_pend = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    cen = 1'b1;
    if (exp_q.size() > 0 && popped < max_beats) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats expected %0d", popped, max_beats);
    end
  endtask

  initial begin
    vec_t vecs[4];
    int cyc;
    beat_t b;

    vecs[0] = '{base: 0,    neg00: 1'b0, alt: 1'b0, exp_cycles: 64};
    vecs[1] = '{base: 0,    neg00: 1'b1, alt: 1'b1, exp_cycles: 127};
    vecs[2] = '{base: 5000, neg00: 1'b0, alt: 1'b1, exp_cycles: 127};
    vecs[3] = '{base: -200, neg00: 1'b1, alt: 1'b0, exp_cycles: 64};

    rst = 1'b1; cen = 1'b1; valid_in = 1'b0; m_ready = 1'b0; result = '0;
    repeat (2) @(negedge clk);
    check("rst_m_valid", W'(m_valid), 0);
    check("rst_in_ready", W'(in_ready), 1);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", W'(m_last), 0);
    check("rst_overrun", W'(overrun), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-matrix streaming, free-flowing and with alternating backpressure.
    for (int v = 0; v < 4; v++) begin
      m_ready = 1'b1;
      capture(vecs[v].base, vecs[v].neg00);
      check("single_first_valid", W'(m_valid), 1);
      check("single_in_ready", W'(in_ready), 1);
      push_exp(vecs[v].base, vecs[v].neg00);
      drain(vecs[v].alt, -1, E, 200, cyc);
      check("single_cycles", W'(cyc), W'(vecs[v].exp_cycles));
      check("single_done_valid", W'(m_valid), 0);
    end

    // Back-to-back captures, then bubble-free streaming of both.
    m_ready = 1'b0;
    valid_in = 1'b1; result = mk_mat(0, 1'b0);
    @(negedge clk);
    result = mk_mat(1000, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    check("b2b_in_ready", W'(in_ready), 0);
    push_exp(0, 1'b0);
    push_exp(1000, 1'b0);
    drain(1'b0, -1, 2 * E, 300, cyc);
    check("b2b_cycles", W'(cyc), 128);
    check("b2b_in_ready_after", W'(in_ready), 1);

    // Overrun: third capture with both slots full is dropped.
    m_ready = 1'b0;
    valid_in = 1'b1; result = mk_mat(0, 1'b0);
    @(negedge clk);
    result = mk_mat(1000, 1'b0);
    @(negedge clk);
    result = mk_mat(2000, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    check("ovr_flag", W'(overrun), 1);
    check("ovr_in_ready", W'(in_ready), 0);
    push_exp(0, 1'b0);
    push_exp(1000, 1'b0);
    drain(1'b0, -1, 2 * E, 300, cyc);
    check("ovr_cycles", W'(cyc), 128);
    check("ovr_empty", W'(m_valid), 0);
    check("ovr_sticky", W'(overrun), 1);

    // Clock enable low for five cycles while beat 10 is presented.
    m_ready = 1'b1;
    capture(0, 1'b0);
    push_exp(0, 1'b0);
    drain(1'b0, 10, E, 200, cyc);
    check("cen_cycles", W'(cyc), 69);

    // Reset mid-stream with a second matrix buffered.
    m_ready = 1'b0;
    valid_in = 1'b1; result = mk_mat(0, 1'b0);
    @(negedge clk);
    result = mk_mat(1000, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    push_exp(0, 1'b0);
    drain(1'b0, -1, 20, 100, cyc);
    check("prerst_data", m_data, 20);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_m_valid", W'(m_valid), 0);
    check("midrst_in_ready", W'(in_ready), 1);
    check("midrst_overrun", W'(overrun), 0);
    check("midrst_m_data", m_data, 0);
    m_ready = 1'b1;
    capture(300, 1'b0);
    check("postrst_first", m_data, 300);
    push_exp(300, 1'b0);
    drain(1'b0, -1, E, 200, cyc);
    check("postrst_cycles", W'(cyc), 64);

    // Capture coinciding with the last beat while full: dropped, slot not reused.
    m_ready = 1'b0;
    valid_in = 1'b1; result = mk_mat(0, 1'b0);
    @(negedge clk);
    result = mk_mat(1000, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    push_exp(0, 1'b0);
    drain(1'b0, -1, E - 1, 200, cyc);
    b = exp_q.pop_front();
    check("edge_last_data", m_data, b.d);
    check("edge_last_flag", W'(m_last), 1);
    m_ready = 1'b1;
    valid_in = 1'b1; result = mk_mat(2000, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    check("edge_overrun", W'(overrun), 1);
    check("edge_in_ready", W'(in_ready), 1);
    check("edge_next_first", m_data, 1000);
    push_exp(1000, 1'b0);
    drain(1'b0, -1, E, 200, cyc);
    check("edge_cycles", W'(cyc), 64);
    check("edge_empty", W'(m_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
